ic_bvugt_bvor_checker: RTL

Sequential witness checker for the bvugt/bvor invertibility condition. It accepts an operand pair `s`, `t` and a candidate witness `x`, such as the value produced by the Skolem-function netlists. It evaluates `(x | s) >u t` bit-serially, MSB first, and independently computes the invertibility condition `t != ~0`. It flags any job where the condition holds but the witness fails. It sits downstream of the Skolem-function blocks as their consumer/verifier in the regression harness.

---
 rtl/ic_bvugt_bvor_checker_if.sv | 25 ++
 rtl/ic_bvugt_bvor_checker.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ic_bvugt_bvor_checker_if.sv
// ic_bvugt_bvor_checker_if: job/result handshake bundle for the bvugt/bvor witness checker.
interface ic_bvugt_bvor_checker_if #(
    parameter int W = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] t;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ready;
    logic         holds;
    logic         ic;
    logic         fail;

    modport master (
        output in_valid, s, t, x, out_ready,
        input  in_ready, out_valid, holds, ic, fail
    );

    modport slave (
        input  in_valid, s, t, x, out_ready,
        output in_ready, out_valid, holds, ic, fail
    );
endinterface

// File: rtl/ic_bvugt_bvor_checker.sv
// ic_bvugt_bvor_checker: bit-serial MSB-first check of (x|s) >u t against the condition t != ~0.
// Define IC_CHECKER_STATS_EN to add saturating job_cnt/fail_cnt outputs.
module ic_bvugt_bvor_checker #(
    parameter int W = 4
) (
    input logic clk,
    input logic rst_n,
    ic_bvugt_bvor_checker_if.slave bus
`ifdef IC_CHECKER_STATS_EN
    ,
    output logic [15:0] job_cnt,
    output logic [15:0] fail_cnt
`endif
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          gt_q, gt_d, lt_q, lt_d, all_q, all_d;
    logic [W-1:0]  s_q, s_d, t_q, t_d, x_q, x_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          holds_q, holds_d, ic_q, ic_d, fail_q, fail_d;
    logic          a, b;

    assign a = x_q[k_q] | s_q[k_q];
    assign b = t_q[k_q];

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        all_d       = all_q;
        s_d         = s_q;
        t_d         = t_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        holds_d     = holds_q;
        ic_d        = ic_q;
        fail_d      = fail_q;
        unique case (state_q)
            IDLE: if (bus.in_valid && in_ready_q) begin
                s_d     = bus.s;
                t_d     = bus.t;
                x_d     = bus.x;
                k_d     = KW'(W - 1);
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                all_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                // The first differing bit from the MSB decides; later bits cannot change it.
                if (!gt_q && !lt_q) begin
                    gt_d = a & ~b;
                    lt_d = ~a & b;
                end
                all_d = all_q & b;
                k_d   = k_q - 1'b1;
                if (k_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    holds_d     = gt_d;
                    ic_d        = ~all_d;
                    fail_d      = ~all_d & ~gt_d;
                end
            end
            DONE: if (bus.out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                holds_d     = 1'b0;
                ic_d        = 1'b0;
                fail_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

`ifdef IC_CHECKER_STATS_EN
    logic [15:0] job_cnt_q, job_cnt_d, fail_cnt_q, fail_cnt_d;
    logic        hs;

    assign hs         = out_valid_q & bus.out_ready;
    assign job_cnt_d  = job_cnt_q + 16'(hs && job_cnt_q != 16'hFFFF);
    assign fail_cnt_d = fail_cnt_q + 16'(hs && fail_q && fail_cnt_q != 16'hFFFF);
    assign job_cnt    = job_cnt_q;
    assign fail_cnt   = fail_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            job_cnt_q  <= '0;
            fail_cnt_q <= '0;
        end else begin
            job_cnt_q  <= job_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            all_q       <= 1'b0;
            s_q         <= '0;
            t_q         <= '0;
            x_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            holds_q     <= 1'b0;
            ic_q        <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            all_q       <= all_d;
            s_q         <= s_d;
            t_q         <= t_d;
            x_q         <= x_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            holds_q     <= holds_d;
            ic_q        <= ic_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.holds     = holds_q;
    assign bus.ic        = ic_q;
    assign bus.fail      = fail_q;
endmodule
